vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receiver end of the team's 640x400 VGA output: samples HS, VS and 8-bit RGB on the system clock, recovers the raster position from the sync edges and decimates 2x2 back to 320x200.
- Emits one framebuffer write per retained pixel. Each write has a linear address and RGB332 data.
- Used for loopback verification of the video generator and as a frame-grab path into the shared framebuffer RAM.

Parameters:
- LINE, 800, expected clocks per line (HS falling edge to HS falling edge).
- SCREEN, 450, expected lines per frame (VS rising edge to VS rising edge).
- H_BACK, 48, clocks from the first sampled HS=1 after a sync pulse to the first active pixel.
- H_ACTIVE, 640, active pixels per line.
- V_BACK, 36, lines from the first HS falling edge after VS falls to the first active line.
- V_ACTIVE, 400, active lines per frame.
- LOCK_FRAMES, 2, consecutive matching frames needed to lock.

Ports:
- clk, in, 1, pixel clock (same clock as the generator).
- rst, in, 1, synchronous reset, active-high.
- hs, in, 1, horizontal sync, active low.
- vs, in, 1, vertical sync, active high.
- rgb, in, 8, pixel data {R[2:0],G[2:0],B[1:0]}.
- wr_en, out, 1, framebuffer write strobe.
- wr_addr, out, 16, write address, y*320+x.
- wr_data, out, 8, write data.
- locked, out, 1, timing lock status.
- frame_done, out, 1, one-cycle pulse after the last write of a frame.
- err_cnt, out, 8, saturating count of timing mismatches.

Behaviour:
- Input stage: hs, vs and rgb are registered once. All edge detection uses the registered copy against its own previous value.
- Edges:
  - HS falling edge = line start.
  - HS rising edge starts the horizontal back-porch counter.
  - VS rising edge = frame start.
  - VS falling edge arms the vertical back-porch line counter.
- Measurement:
  - hcnt (10 bits) counts clocks between HS falling edges and is captured on each falling edge.
  - vcnt (10 bits) counts HS falling edges between VS rising edges and is captured on each VS rising edge.
  - Both counters saturate at 1023.
- Lock FSM, evaluated on each VS rising edge:
  - SEARCH: the first VS rising edge goes to CHECK with match_cnt=0.
  - CHECK: if every captured hcnt in the frame equalled LINE and vcnt==SCREEN, increment match_cnt. On reaching LOCK_FRAMES go to LOCKED. On a mismatch clear match_cnt and stay in CHECK.
  - LOCKED: any hcnt!=LINE (checked at each HS falling edge) or vcnt!=SCREEN returns to CHECK immediately, increments err_cnt (saturating at 255) and drops locked on the next cycle.
- locked=1 only in LOCKED.
- Active window:
  - Active column px = clocks since the first registered HS=1, minus H_BACK, valid for 0..H_ACTIVE-1.
  - Active row py = line index since VS falling edge, minus V_BACK, valid for 0..V_ACTIVE-1.
- Write rule:
  - wr_en=1 iff locked, px and py are in range, px[0]==0 and py[0]==0.
  - wr_addr = (py>>1)*320 + (px>>1), computed as (y<<8)+(y<<6)+x. No multiplier.
  - wr_data = the registered rgb of that sample.
  - Write outputs are registered: 2 cycles from the rgb pin to wr_en/wr_data.
  - Maximum address 63999. A wr_addr >= 64000 never occurs.
- frame_done:
  - Pulses 1 cycle after the write to addr 63999.
  - Never pulses when unlocked. A frame in which lock is lost mid-frame produces no frame_done.
- Lock lost mid-frame: wr_en goes to 0 from the cycle after the mismatch, with no further writes until re-lock and the next VS rising edge.
- Simultaneous HS and VS edges in one cycle: the VS edge is processed first, then the HS edge counts as line 0 of the new frame.
- rst at any time:
  - FSM goes to SEARCH and all counters clear.
  - Outputs wr_en=0, wr_addr=0, wr_data=0, locked=0, frame_done=0, err_cnt=0.
  - The next VS rising edge restarts measurement.
- Missing sync: the saturated hcnt or vcnt mismatches at the next edge and is handled as a normal mismatch.

Test Plan:
- Connect vga (the team's 640x400 generator) to vga_capture, with rst held 4 cycles → locked rises at the 3rd VS rising edge (after 2 matching frames). err_cnt=0.
- Locked, generator buffer pattern: row 0 with the left half 1 → wr_data=0xFF at addr 0..159, 0x25 at addr 160..319. Exactly 64000 writes per frame, frame_done once per frame.
- Stretch one line to 801 clocks while locked → locked=0 within 2 cycles of that HS falling edge, err_cnt=1, no writes until re-locked 2 frames later.
- Stimulus with SCREEN=449 lines per frame → lock never asserted, wr_en never high.
- Assert rst mid-frame at row 100 → all outputs 0 next cycle, FSM back to SEARCH, lock regained after 2 full frames.
- Assert HS falling and VS rising in the same cycle → that line counted as line 0 of the new frame. The first write of the frame lands at addr 0.

Source files
------------

// File: rtl/vga_capture.sv
// VGA loopback receiver: recovers raster position from the sync edges, checks the timing
// and writes every second pixel of every second line into a 320-wide RGB332 framebuffer.
module vga_capture #(
    parameter int LINE        = 800,
    parameter int SCREEN      = 450,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_BACK      = 36,
    parameter int V_ACTIVE    = 400,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic [7:0]  rgb,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        locked,
    output logic        frame_done,
    output logic [7:0]  err_cnt
);
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [9:0] CNT_MAX  = 10'd1023;
    localparam logic [9:0] LINE_W   = 10'(LINE);
    localparam logic [9:0] SCREEN_W = 10'(SCREEN);
    localparam logic [9:0] H_START  = 10'(H_BACK);
    localparam logic [9:0] H_STOP   = 10'(H_BACK + H_ACTIVE);
    localparam logic [9:0] V_START  = 10'(V_BACK);
    localparam logic [9:0] V_STOP   = 10'(V_BACK + V_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE - 2);
    localparam logic [8:0] V_LAST   = 9'(V_ACTIVE - 2);
    localparam logic [7:0] LOCK_W   = 8'(LOCK_FRAMES);

    logic        hs_reg, vs_reg, hs_d_reg, vs_d_reg;
    logic [7:0]  rgb_reg;
    logic [9:0]  hcnt_reg, vcnt_reg, hpos_reg, vline_reg;
    logic        h_seen_reg, v_arm_reg, v_valid_reg, line_bad_reg;
    logic [1:0]  state_reg;
    logic [7:0]  match_reg, err_reg;
    logic        wr_en_reg, wr_last_reg, frame_done_reg;
    logic [15:0] wr_addr_reg;
    logic [7:0]  wr_data_reg;

    logic        hs_fall, hs_rise, vs_rise, vs_fall;
    logic        h_bad, v_bad, lose_lock;
    logic        h_active, v_active, wr_next, wr_last_next, frame_done_next;
    logic [9:0]  h_meas, cur_h, px;
    logic [8:0]  py;
    logic [15:0] y16, x16, addr_next;

    assign hs_fall = hs_d_reg & ~hs_reg;
    assign hs_rise = ~hs_d_reg & hs_reg;
    assign vs_rise = ~vs_d_reg & vs_reg;
    assign vs_fall = vs_d_reg & ~vs_reg;

    // Captured line length includes the clock of the closing falling edge.
    assign h_meas    = (hcnt_reg == CNT_MAX) ? CNT_MAX : hcnt_reg + 10'd1;
    assign h_bad     = hs_fall && (h_meas != LINE_W);
    assign v_bad     = (vcnt_reg != SCREEN_W);
    assign lose_lock = (state_reg == LOCKED) && (h_bad || (vs_rise && v_bad));

    always_comb begin
        cur_h = 10'd0;
        if (!hs_rise) begin
            cur_h = (hpos_reg == CNT_MAX) ? CNT_MAX : hpos_reg + 10'd1;
        end
    end

    assign px       = cur_h - H_START;
    assign py       = 9'(vline_reg - V_START);
    assign h_active = (h_seen_reg || hs_rise) && (cur_h >= H_START) && (cur_h < H_STOP);
    assign v_active = v_valid_reg && (vline_reg >= V_START) && (vline_reg < V_STOP);

    assign wr_next = (state_reg == LOCKED) && !lose_lock && h_active && v_active
                     && !px[0] && !py[0];
    assign wr_last_next    = wr_next && (px == H_LAST) && (py == V_LAST);
    assign frame_done_next = wr_last_reg && (state_reg == LOCKED) && !lose_lock;

    // y*320 + x as two shifts and an add.
    assign y16       = {8'd0, py[8:1]};
    assign x16       = {7'd0, px[9:1]};
    assign addr_next = (y16 << 8) + (y16 << 6) + x16;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_reg   <= 1'b0;
            vs_reg   <= 1'b0;
            hs_d_reg <= 1'b0;
            vs_d_reg <= 1'b0;
            rgb_reg  <= 8'd0;
        end else begin
            hs_reg   <= hs;
            vs_reg   <= vs;
            hs_d_reg <= hs_reg;
            vs_d_reg <= vs_reg;
            rgb_reg  <= rgb;
        end
    end

    // A line edge coinciding with the frame edge is line 0 of the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_reg <= 10'd0;
            vcnt_reg <= 10'd0;
        end else begin
            hcnt_reg <= hs_fall ? 10'd0 : h_meas;
            if (vs_rise) begin
                vcnt_reg <= {9'd0, hs_fall};
            end else if (hs_fall && vcnt_reg != CNT_MAX) begin
                vcnt_reg <= vcnt_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hpos_reg    <= 10'd0;
            h_seen_reg  <= 1'b0;
            vline_reg   <= 10'd0;
            v_arm_reg   <= 1'b0;
            v_valid_reg <= 1'b0;
        end else begin
            hpos_reg <= cur_h;
            if (hs_rise) begin
                h_seen_reg <= 1'b1;
            end
            if (vs_rise) begin
                v_arm_reg   <= 1'b0;
                v_valid_reg <= 1'b0;
                vline_reg   <= 10'd0;
            end else if (vs_fall) begin
                v_arm_reg   <= 1'b1;
                v_valid_reg <= 1'b0;
                vline_reg   <= 10'd0;
            end else if (hs_fall && v_arm_reg) begin
                v_valid_reg <= 1'b1;
                if (v_valid_reg && vline_reg != CNT_MAX) begin
                    vline_reg <= vline_reg + 10'd1;
                end
            end
        end
    end

    // Lines measured before the first frame edge after reset are not trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_bad_reg <= 1'b0;
        end else if (state_reg == SEARCH) begin
            line_bad_reg <= 1'b0;
        end else if (vs_rise) begin
            line_bad_reg <= h_bad;
        end else if (h_bad) begin
            line_bad_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SEARCH;
            match_reg <= 8'd0;
            err_reg   <= 8'd0;
        end else begin
            case (state_reg)
                SEARCH: begin
                    if (vs_rise) begin
                        state_reg <= CHECK;
                        match_reg <= 8'd0;
                    end
                end
                CHECK: begin
                    if (vs_rise) begin
                        if (!line_bad_reg && !v_bad) begin
                            match_reg <= match_reg + 8'd1;
                            if (match_reg + 8'd1 >= LOCK_W) begin
                                state_reg <= LOCKED;
                            end
                        end else begin
                            match_reg <= 8'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (lose_lock) begin
                        state_reg <= CHECK;
                        match_reg <= 8'd0;
                        if (err_reg != 8'hFF) begin
                            err_reg <= err_reg + 8'd1;
                        end
                    end
                end
                default: state_reg <= SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= 16'd0;
            wr_data_reg    <= 8'd0;
            wr_last_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            wr_en_reg      <= wr_next;
            wr_last_reg    <= wr_last_next;
            frame_done_reg <= frame_done_next;
            if (wr_next) begin
                wr_addr_reg <= addr_next;
                wr_data_reg <= rgb_reg;
            end
        end
    end

    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign locked     = (state_reg == LOCKED);
    assign frame_done = frame_done_reg;
    assign err_cnt    = err_reg;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a shrunken raster (40x20 total, 16x8 active): a scenario table
// of frame sequences with expected lock/write/error outcomes, plus a per-cycle write monitor.
module tb_vga_capture;
    localparam int LINE     = 40;
    localparam int SCREEN   = 20;
    localparam int H_BACK   = 4;
    localparam int H_ACTIVE = 16;
    localparam int V_BACK   = 2;
    localparam int V_ACTIVE = 8;
    localparam int HSYNC    = 4;
    localparam int VSYNC    = 2;
    localparam int H_FIRST  = HSYNC + H_BACK;
    localparam int V_FIRST  = VSYNC + 1 + V_BACK;
    localparam int XW       = H_ACTIVE / 2;
    localparam int YH       = V_ACTIVE / 2;
    localparam int LAST_ADDR = (YH - 1) * 320 + XW - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs  = 1'b1;
    logic        vs  = 1'b0;
    logic [7:0]  rgb = 8'd0;
    logic        wr_en, locked, frame_done;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data, err_cnt;

    vga_capture #(
        .LINE(LINE), .SCREEN(SCREEN), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE),
        .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .rgb(rgb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .locked(locked), .frame_done(frame_done), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, wr_cnt = 0, fd_cnt = 0, k_idx = 0, first_addr = -1;
    int rise_cyc = 0, fall_cyc = 0, vs_mark = 0, hs_mark = 0;
    logic locked_prev = 1'b0, vs_prev = 1'b0, wr_prev = 1'b0;
    int addr_prev = 0;

    typedef struct {
        int   nlines;
        int   nframes;
        int   long_line;
        int   rst_line;
        int   edge_chk;
        logic exp_locked;
        int   exp_writes;
        int   exp_fd;
        int   exp_err;
    } row_t;
    row_t rows[12];

    function automatic logic [7:0] pix(input int ay, input int ax);
        return 8'((ay * 16 + ax) ^ 8'h3C);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, then inspect outputs at the next one.
    task automatic step(input logic h, input logic v, input logic [7:0] p, input logic r);
        int ey, ex, ea;
        logic [7:0] ed;
        hs = h; vs = v; rgb = p; rst = r;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (r) begin
            n_checks++;
            if (wr_en !== 1'b0 || wr_addr !== 16'd0 || wr_data !== 8'd0 || locked !== 1'b0
                || frame_done !== 1'b0 || err_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: wr_en=%b addr=%0d data=%02h locked=%b fd=%b err=%0d, expected all 0",
                         wr_en, wr_addr, wr_data, locked, frame_done, err_cnt);
            end
        end
        if (locked && !locked_prev) rise_cyc = cyc;
        if (!locked && locked_prev) fall_cyc = cyc;
        if (v && !vs_prev) k_idx = 0;
        if (wr_en) begin
            ey = k_idx / XW;
            ex = k_idx % XW;
            ea = ey * 320 + ex;
            ed = pix(2 * ey, 2 * ex);
            n_checks++;
            if (int'(wr_addr) != ea || wr_data !== ed) begin
                n_fail++;
                $display("FAIL write[%0d]: addr=%0d data=%02h, expected addr=%0d data=%02h",
                         k_idx, wr_addr, wr_data, ea, ed);
            end
            if (k_idx == 0) first_addr = int'(wr_addr);
            k_idx++;
            wr_cnt++;
        end
        if (frame_done) begin
            fd_cnt++;
            n_checks++;
            if (!wr_prev || addr_prev != LAST_ADDR) begin
                n_fail++;
                $display("FAIL frame_done_timing: prev wr_en=%b prev addr=%0d, expected 1 and %0d",
                         wr_prev, addr_prev, LAST_ADDR);
            end
        end
        locked_prev = locked;
        vs_prev     = v;
        wr_prev     = wr_en;
        addr_prev   = int'(wr_addr);
    endtask

    // VS and the HS falling edge change together at the start of line 0.
    task automatic gen_frame(input int nlines, input int long_line, input int rst_line);
        int len;
        logic [7:0] p;
        for (int l = 0; l < nlines; l++) begin
            len = (l == long_line) ? LINE + 1 : LINE;
            for (int c = 0; c < len; c++) begin
                p = 8'hEE;
                if (l >= V_FIRST && l < V_FIRST + V_ACTIVE && c >= H_FIRST && c < H_FIRST + H_ACTIVE)
                    p = pix(l - V_FIRST, c - H_FIRST);
                if (l == 0 && c == 0) vs_mark = cyc + 1;
                if (long_line >= 0 && l == long_line + 1 && c == 0) hs_mark = cyc + 1;
                step(c >= HSYNC, l < VSYNC, p, (l == rst_line) && (c == H_FIRST + 4));
            end
        end
    endtask

    initial begin
        int w0, f0;
        // nlines, nframes, long_line, rst_line(-2 = before), edge_chk, locked, writes, fd, err
        rows[0]  = '{20, 2, -1, -2, 0, 1'b0,  0, 0, 0};
        rows[1]  = '{20, 1, -1, -1, 1, 1'b1, 32, 1, 0};
        rows[2]  = '{20, 2, -1, -1, 0, 1'b1, 64, 2, 0};
        rows[3]  = '{20, 1,  7, -1, 2, 1'b0, 16, 0, 1};
        rows[4]  = '{20, 1, -1, -1, 0, 1'b0,  0, 0, 1};
        rows[5]  = '{20, 1, -1, -1, 0, 1'b0,  0, 0, 1};
        rows[6]  = '{20, 1, -1, -1, 1, 1'b1, 32, 1, 1};
        rows[7]  = '{19, 4, -1, -2, 0, 1'b0,  0, 0, 0};
        rows[8]  = '{20, 3, -1, -1, 1, 1'b1, 32, 1, 0};
        rows[9]  = '{20, 1, -1,  6, 0, 1'b0,  8, 0, 0};
        rows[10] = '{20, 2, -1, -1, 0, 1'b0,  0, 0, 0};
        rows[11] = '{20, 1, -1, -1, 1, 1'b1, 32, 1, 0};

        for (int i = 0; i < 12; i++) begin
            if (rows[i].rst_line == -2) begin
                for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 8'h00, 1'b1);
                for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 8'h00, 1'b0);
            end
            w0 = wr_cnt;
            f0 = fd_cnt;
            for (int f = 0; f < rows[i].nframes; f++)
                gen_frame(rows[i].nlines, rows[i].long_line, rows[i].rst_line);
            $display("row %0d: lines=%0d frames=%0d writes=%0d frame_done=%0d err=%0d locked=%0b",
                     i, rows[i].nlines, rows[i].nframes, wr_cnt - w0, fd_cnt - f0, err_cnt, locked);
            check($sformatf("row%0d locked", i), int'(locked), int'(rows[i].exp_locked));
            check($sformatf("row%0d writes", i), wr_cnt - w0, rows[i].exp_writes);
            check($sformatf("row%0d frame_done", i), fd_cnt - f0, rows[i].exp_fd);
            check($sformatf("row%0d err_cnt", i), int'(err_cnt), rows[i].exp_err);
            if (rows[i].exp_writes > 0)
                check($sformatf("row%0d first_addr", i), first_addr, 0);
            if (rows[i].edge_chk == 1)
                check($sformatf("row%0d lock_rise_latency", i), rise_cyc - vs_mark, 1);
            if (rows[i].edge_chk == 2)
                check($sformatf("row%0d lock_fall_latency", i), fall_cyc - hs_mark, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
